// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles, LSB first.
// Result {cout,sum} = a + b + cin, published on the RUN->DONE edge and held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;
    logic             last;

    always_comb begin
        s    = a_sh[0] ^ b_sh[0] ^ carry;
        c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last = (cnt == CW'(WIDTH - 1));
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts start as well, giving back-to-back operation
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= {s, r_sh[WIDTH-1:1]};
                    carry <= c;
                    if (last) begin
                        sum   <= {s, r_sh[WIDTH-1:1]};
                        cout  <= c;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus randomized operands
// compared against plain integer addition.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return r;
    endfunction

    // Drives one start pulse and waits (bounded) for done; reports latency in edges after the accept edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input bit from_idle, output int lat, output int bcnt,
                          output logic [W-1:0] osum, output logic ocout);
        if (from_idle) @(posedge clk);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        osum = sum;
        ocout = cout;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = 'x; b = 'x; cin = 1'bx;
        #13;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all zero", busy, done, cout, sum);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            errors++;
            $display("FAIL idle_x_inputs: got busy=%b done=%b cout=%b sum=%h, want all zero", busy, done, cout, sum);
        end
        a = '0; b = '0; cin = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int lat, bcnt;
        logic [W-1:0] s;
        logic co;
        logic [W:0] exp;
        exp = ref_add(ta, tb, tc);
        run_op(ta, tb, tc, 1'b1, lat, bcnt, s, co);
        checks++;
        if ({co, s} !== exp) begin
            errors++;
            $display("FAIL %s_result: got cout=%b sum=%h, want cout=%b sum=%h", name, co, s, exp[W], exp[W-1:0]);
        end
        checks++;
        if (lat != W || bcnt != W) begin
            errors++;
            $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d, want %0d/%0d", name, lat, bcnt, W, W);
        end
    endtask

    task automatic test_basic;
        check_op("basic", 8'h5A, 8'h3C, 1'b0);
        checks++;
        if (sum !== 8'h96 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_const: got cout=%b sum=%h, want cout=0 sum=96", cout, sum);
        end
    endtask

    task automatic test_overflow;
        check_op("ovf1", 8'hFF, 8'h01, 1'b0);
        check_op("ovf2", 8'hFF, 8'hFF, 1'b1);
        check_op("zero", 8'h00, 8'h00, 1'b0);
        check_op("cin_only", 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_ignore_busy;
        int dcnt, bcnt;
        logic [W-1:0] dsum;
        logic dcout;
        dcnt = 0; bcnt = 0; dsum = '0; dcout = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy === 1'b1) bcnt++;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                @(negedge clk);
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                dcnt++;
                dsum = sum;
                dcout = cout;
            end
        end
        checks++;
        if (dcnt != 1 || bcnt != W) begin
            errors++;
            $display("FAIL ignore_busy_count: got done=%0d busy=%0d, want 1/%0d", dcnt, bcnt, W);
        end
        checks++;
        if (dsum !== 8'h30 || dcout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_result: got cout=%b sum=%h, want cout=0 sum=30", dcout, dsum);
        end
    endtask

    task automatic test_back_to_back;
        int lat, guard;
        int bad_hold;
        @(posedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (done !== 1'b1 || sum !== 8'h02 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got done=%b cout=%b sum=%h, want done=1 cout=0 sum=02", done, cout, sum);
        end
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        lat = 0;
        bad_hold = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (sum !== 8'h02) bad_hold++;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bad_hold != 0) begin
            errors++;
            $display("FAIL b2b_sum_hold: got %0d cycles with sum changed during RUN, want 0", bad_hold);
        end
        checks++;
        if (lat != W || sum !== 8'h01 || cout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got latency=%0d cout=%b sum=%h, want %0d cout=1 sum=01", lat, cout, sum, W);
        end
    endtask

    task automatic test_reset_midop;
        int dcnt;
        @(posedge clk);
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: got busy=%b done=%b cout=%b sum=%h, want 0/0/0/00", busy, done, cout, sum);
        end
        #8;
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles after reset, want 0", dcnt);
        end
        check_op("after_reset", 8'h7F, 8'h01, 1'b0);
    endtask

    task automatic test_random;
        int lat, bcnt, nerr;
        logic [W-1:0] ra, rb, s;
        logic rc, co;
        logic [W:0] exp;
        nerr = 0;
        for (int i = 0; i < 1500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, ($urandom_range(0, 3) != 0), lat, bcnt, s, co);
            checks++;
            if ({co, s} !== exp) begin
                errors++;
                if (nerr++ < 10)
                    $display("FAIL random_result: a=%h b=%h cin=%b got cout=%b sum=%h, want cout=%b sum=%h",
                             ra, rb, rc, co, s, exp[W], exp[W-1:0]);
            end
            checks++;
            if (lat != W || bcnt != W) begin
                errors++;
                if (nerr++ < 10)
                    $display("FAIL random_timing: got latency=%0d busy_cycles=%0d, want %0d/%0d", lat, bcnt, W, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
